scs8hd_a4oi_pipe: RTL and testbench

//  Multi-channel, parametrised AND-OR-INVERT evaluator with a registered valid/ready pipeline.

---
 rtl/scs8hd_a4oi_pipe_if.sv | 28 ++
 rtl/scs8hd_a4oi_pipe.sv | 82 ++++++++
 tb/tb_scs8hd_a4oi_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/scs8hd_a4oi_pipe_if.sv
// Bundle for the AOI pipeline: upstream valid/ready, operands, downstream valid/ready, result, counter.
// Valid/ready: a transfer happens on a rising edge where valid & ready are both high; once valid is
// raised the producer holds it and its payload stable until that transfer, and valid never waits on ready.
interface scs8hd_a4oi_pipe_if #(
    parameter int CHANNELS = 4,
    parameter int N_AND    = 4,
    parameter int CNT_W    = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*N_AND-1:0] A;
    logic [CHANNELS-1:0]       B1;
    logic [N_AND-1:0]          A_mask;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS-1:0]       Y;
    logic [CNT_W-1:0]          xfer_count;

    modport master (
        output in_valid, A, B1, A_mask, out_ready,
        input  in_ready, out_valid, Y, xfer_count
    );

    modport slave (
        input  in_valid, A, B1, A_mask, out_ready,
        output in_ready, out_valid, Y, xfer_count
    );
endinterface

// File: rtl/scs8hd_a4oi_pipe.sv
// Multi-channel masked AND-OR-INVERT evaluator feeding a DEPTH-stage elastic valid/ready pipeline,
// with a wrapping count of completed output transfers.
module scs8hd_a4oi_pipe #(
    parameter int CHANNELS = 4,
    parameter int N_AND    = 4,
    parameter int DEPTH    = 2,
    parameter int INVERT   = 1,
    parameter int CNT_W    = 16
) (
    input logic               CLK,
    input logic               RESET,
    scs8hd_a4oi_pipe_if.slave bus
);

    if ((DEPTH < 1) || (DEPTH > 4)) begin : g_depth_err
        $error("scs8hd_a4oi_pipe: DEPTH=%0d outside 1..4", DEPTH);
    end
    if (N_AND < 1) begin : g_nand_err
        $error("scs8hd_a4oi_pipe: N_AND=%0d must be >= 1", N_AND);
    end

    logic [DEPTH-1:0]    v;
    logic [CHANNELS-1:0] data [DEPTH];
    logic [DEPTH-1:0]    advance;
    logic [DEPTH-1:0]    load;
    logic [CHANNELS-1:0] eval;
    logic [CNT_W-1:0]    count_q;

    always_comb begin
        logic [N_AND-1:0] a_eff;
        logic             or_term;
        a_eff   = '0;
        or_term = 1'b0;
        eval    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            a_eff   = bus.A[c*N_AND +: N_AND] | ~bus.A_mask;
            or_term = (&a_eff) | bus.B1[c];
            eval[c] = (INVERT != 0) ? ~or_term : or_term;
        end
    end

    // A stage empties this cycle if the output drains or any stage downstream of it is a bubble;
    // this is the unrolled form of advance[k] = ~v[k+1] | advance[k+1].
    always_comb begin
        advance = '0;
        for (int k = 0; k < DEPTH; k++) begin
            advance[k] = bus.out_ready;
            for (int j = k + 1; j < DEPTH; j++) begin
                if (!v[j]) advance[k] = 1'b1;
            end
        end
    end

    assign load = ~v | advance;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v       <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) data[k] <= '0;
        end else begin
            if (load[0]) begin
                v[0] <= bus.in_valid;
                if (bus.in_valid) data[0] <= eval;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) data[k] <= data[k-1];
                end
            end
            if (v[DEPTH-1] && bus.out_ready) count_q <= count_q + CNT_W'(1);
        end
    end

    // Held low through reset so nothing presented in the reset cycle looks accepted.
    assign bus.in_ready   = ~RESET & load[0];
    assign bus.out_valid  = v[DEPTH-1];
    assign bus.Y          = data[DEPTH-1];
    assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_scs8hd_a4oi_pipe.sv
// Directed bench for scs8hd_a4oi_pipe: default build plus INVERT=0, CNT_W=4, DEPTH=1 and DEPTH=4 builds
// driven by one shared stimulus.
module tb_scs8hd_a4oi_pipe;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] A = '0;
    logic [3:0]  B1 = '0;
    logic [3:0]  A_mask = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    scs8hd_a4oi_pipe_if #(.CHANNELS(4), .N_AND(4), .CNT_W(16)) bus_main ();
    scs8hd_a4oi_pipe_if #(.CHANNELS(4), .N_AND(4), .CNT_W(16)) bus_inv0 ();
    scs8hd_a4oi_pipe_if #(.CHANNELS(4), .N_AND(4), .CNT_W(4))  bus_w4 ();
    scs8hd_a4oi_pipe_if #(.CHANNELS(4), .N_AND(4), .CNT_W(16)) bus_d1 ();
    scs8hd_a4oi_pipe_if #(.CHANNELS(4), .N_AND(4), .CNT_W(16)) bus_d4 ();

    assign bus_main.in_valid = in_valid;  assign bus_main.out_ready = out_ready;
    assign bus_main.A = A;  assign bus_main.B1 = B1;  assign bus_main.A_mask = A_mask;
    assign bus_inv0.in_valid = in_valid;  assign bus_inv0.out_ready = out_ready;
    assign bus_inv0.A = A;  assign bus_inv0.B1 = B1;  assign bus_inv0.A_mask = A_mask;
    assign bus_w4.in_valid = in_valid;    assign bus_w4.out_ready = out_ready;
    assign bus_w4.A = A;    assign bus_w4.B1 = B1;    assign bus_w4.A_mask = A_mask;
    assign bus_d1.in_valid = in_valid;    assign bus_d1.out_ready = out_ready;
    assign bus_d1.A = A;    assign bus_d1.B1 = B1;    assign bus_d1.A_mask = A_mask;
    assign bus_d4.in_valid = in_valid;    assign bus_d4.out_ready = out_ready;
    assign bus_d4.A = A;    assign bus_d4.B1 = B1;    assign bus_d4.A_mask = A_mask;

    scs8hd_a4oi_pipe #(.CHANNELS(4), .N_AND(4), .DEPTH(2), .INVERT(1), .CNT_W(16))
        dut_main (.CLK(CLK), .RESET(RESET), .bus(bus_main.slave));
    scs8hd_a4oi_pipe #(.CHANNELS(4), .N_AND(4), .DEPTH(2), .INVERT(0), .CNT_W(16))
        dut_inv0 (.CLK(CLK), .RESET(RESET), .bus(bus_inv0.slave));
    scs8hd_a4oi_pipe #(.CHANNELS(4), .N_AND(4), .DEPTH(2), .INVERT(1), .CNT_W(4))
        dut_w4 (.CLK(CLK), .RESET(RESET), .bus(bus_w4.slave));
    scs8hd_a4oi_pipe #(.CHANNELS(4), .N_AND(4), .DEPTH(1), .INVERT(1), .CNT_W(16))
        dut_d1 (.CLK(CLK), .RESET(RESET), .bus(bus_d1.slave));
    scs8hd_a4oi_pipe #(.CHANNELS(4), .N_AND(4), .DEPTH(4), .INVERT(1), .CNT_W(16))
        dut_d4 (.CLK(CLK), .RESET(RESET), .bus(bus_d4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2-3 time units after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] b1_tab [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    logic [3:0] y_tab  [6] = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};

    initial begin
        int n_in;
        int n_out;
        logic [3:0] exp_y;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_in_ready", 32'(bus_main.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus_main.out_valid), 32'd0);
        check("rst_y", 32'(bus_main.Y), 32'd0);
        check("rst_xfer", 32'(bus_main.xfer_count), 32'd0);
        RESET = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(bus_main.in_ready), 32'd1);

        // T1 basic and latency sweep
        A = 16'hFFFF; A_mask = 4'hF; B1 = 4'h0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_main_ov_e0", 32'(bus_main.out_valid), 32'd0);
        check("t1_d1_ov_e0", 32'(bus_d1.out_valid), 32'd1);
        check("t1_d1_y", 32'(bus_d1.Y), 32'h0);
        tick();
        #1;
        check("t1_main_ov_e1", 32'(bus_main.out_valid), 32'd1);
        check("t1_main_y", 32'(bus_main.Y), 32'h0);
        check("t1_inv0_y", 32'(bus_inv0.Y), 32'hF);
        check("t1_d1_ov_e1", 32'(bus_d1.out_valid), 32'd0);
        check("t1_d4_ov_e1", 32'(bus_d4.out_valid), 32'd0);
        tick();
        #1;
        check("t1_main_xfer", 32'(bus_main.xfer_count), 32'd1);
        check("t1_main_ov_e2", 32'(bus_main.out_valid), 32'd0);
        check("t1_d4_ov_e2", 32'(bus_d4.out_valid), 32'd0);
        tick();
        #1;
        check("t1_d4_ov_e3", 32'(bus_d4.out_valid), 32'd1);
        tick();
        tick();

        // T2 per-channel mix
        A = 16'h0F00; B1 = 4'b0001; A_mask = 4'hF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        check("t2_main_ov", 32'(bus_main.out_valid), 32'd1);
        check("t2_main_y", 32'(bus_main.Y), 32'b1010);
        check("t2_inv0_y", 32'(bus_inv0.Y), 32'b0101);
        tick();
        tick();
        tick();
        check("t2_main_xfer", 32'(bus_main.xfer_count), 32'd2);

        // T3 mask: partial mask then fully masked
        A = 16'h7777; A_mask = 4'h7; B1 = 4'h0; in_valid = 1'b1;
        tick();
        A = 16'h0000; A_mask = 4'h0;
        #1;
        check("t3_d1_y_partial", 32'(bus_d1.Y), 32'h0);
        check("t3_d1_inv_partial_ov", 32'(bus_d1.out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("t3_main_y_partial", 32'(bus_main.Y), 32'h0);
        check("t3_inv0_y_partial", 32'(bus_inv0.Y), 32'hF);
        tick();
        #1;
        check("t3_main_ov_nomask", 32'(bus_main.out_valid), 32'd1);
        check("t3_main_y_nomask", 32'(bus_main.Y), 32'h0);
        check("t3_inv0_y_nomask", 32'(bus_inv0.Y), 32'hF);
        tick();
        tick();
        tick();
        check("t3_main_xfer", 32'(bus_main.xfer_count), 32'd4);

        // T4 backpressure: stall 5 cycles, then release while streaming
        do_reset();
        A = 16'h0000; A_mask = 4'hF;
        n_in = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid = (n_in < 6);
            B1 = (n_in < 6) ? b1_tab[n_in] : 4'h0;
            #1;
            if (in_valid && bus_main.in_ready) begin
                exp_q.push_back(y_tab[n_in]);
                n_in++;
            end
            if (cyc == 4) begin
                check("t4_accepted_in_stall", 32'(n_in), 32'd2);
                check("t4_in_ready_full", 32'(bus_main.in_ready), 32'd0);
                check("t4_y_hold", 32'(bus_main.Y), 32'hE);
            end
            if (bus_main.out_valid && out_ready) begin
                exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hX;
                check("t4_y_order", 32'(bus_main.Y), 32'(exp_y));
                n_out++;
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("t4_items_out", 32'(n_out), 32'd6);
        check("t4_xfer", 32'(bus_main.xfer_count), 32'd6);
        check("t4_drained", 32'(bus_main.out_valid), 32'd0);

        // T5 reset with two entries in flight
        out_ready = 1'b0; A = 16'h0000; A_mask = 4'hF; B1 = 4'h1; in_valid = 1'b1;
        tick();
        tick();
        RESET = 1'b1;
        #1;
        check("t5_in_ready_in_reset", 32'(bus_main.in_ready), 32'd0);
        tick();
        RESET = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t5_ov", 32'(bus_main.out_valid), 32'd0);
        check("t5_xfer", 32'(bus_main.xfer_count), 32'd0);
        check("t5_y", 32'(bus_main.Y), 32'h0);
        check("t5_in_ready", 32'(bus_main.in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t5_no_output", 32'(bus_main.xfer_count), 32'd0);

        // T6 counter wrap on the CNT_W=4 build
        do_reset();
        A = 16'h0000; B1 = 4'h0; A_mask = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t6_w4_wrap", 32'(bus_w4.xfer_count), 32'd1);
        check("t6_main_xfer", 32'(bus_main.xfer_count), 32'd17);
        check("t6_d1_xfer", 32'(bus_d1.xfer_count), 32'd17);
        check("t6_d4_xfer", 32'(bus_d4.xfer_count), 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
